// File: rtl/subbytes_iter_if.sv
// Handshake bundle for the iterative SubBytes engine: input state channel,
// output state channel toward ShiftRows, and the busy status flag.
interface subbytes_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/subbytes_iter.sv
// Iterative AES (Inv)SubBytes, LANES bytes per cycle; latency 16/LANES cycles after accept.
// Result is held in DONE until out_ready; a new block may be accepted on the same edge.
module subbytes_iter #(
  parameter int LANES = 4
) (
  input logic           clk,
  input logic           rst_n,
  subbytes_iter_if.slave bus
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // FIPS-197 tables, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return inv ? SBOX_INV[idx +: 8] : SBOX_FWD[idx +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           inv_r;
  logic [127:0]   work, work_nxt;
  logic           out_valid_r, busy_r;
  logic           rdy, accept;

  always_comb begin
    state_nxt = state;
    rdy       = (state == IDLE) | ((state == DONE) & bus.out_ready);
    accept    = bus.in_valid & rdy;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (cnt == LAST) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Substitute the LANES bytes addressed by cnt, byte 0 being the MSB.
  always_comb begin
    int pos;
    pos      = 0;
    work_nxt = work;
    for (int l = 0; l < LANES; l++) begin
      pos = int'(cnt) * LANES + l;
      work_nxt[(15 - pos) * 8 +: 8] = sbox(work[(15 - pos) * 8 +: 8], inv_r);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      inv_r       <= 1'b0;
      work        <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      out_valid_r <= (state_nxt == DONE);
      busy_r      <= (state_nxt != IDLE);
      if (accept) begin
        work  <= bus.in_data;
        inv_r <= bus.in_inv;
        cnt   <= '0;
      end else if (state == RUN) begin
        work <= work_nxt;
        cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = work;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_subbytes_iter.sv
// Directed bench for subbytes_iter: five instances (LANES 1..16) share one stimulus;
// functional checks target the LANES=4 instance, the sweep compares all five.
module tb_subbytes_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_inv = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] in_data = '0;

  logic [4:0]   ov, ir, by;
  logic [127:0] od [5];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 5; g++) begin : g_dut
    subbytes_iter_if bus ();
    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.in_inv    = in_inv;
    assign bus.out_ready = out_ready;
    subbytes_iter #(.LANES(1 << g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign ov[g] = bus.out_valid;
    assign od[g] = bus.out_data;
    assign ir[g] = bus.in_ready;
    assign by[g] = bus.busy;
  end

  localparam logic [127:0] PT  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] SUB = 128'hd42711aee0bf98f1b8b45de51e415230;

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Waits for out_valid on the LANES=4 instance; lat counts edges after the accept edge.
  task automatic wait_out(output logic [127:0] res, output int lat);
    lat = -1;
    res = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (ov[2]) begin
        lat = k;
        res = od[2];
        break;
      end
    end
  endtask

  task automatic run_block(input logic [127:0] d, input logic inv,
                           output logic [127:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_inv   = ~inv;
    in_data  = '0;
    wait_out(res, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] res, held;
    int           lat, pulses;
    int           slat [5];
    logic [127:0] sres [5];

    vecs[0] = '{PT, 1'b0, SUB};
    vecs[1] = '{SUB, 1'b1, PT};
    vecs[2] = '{128'h0, 1'b0, {16{8'h63}}};
    vecs[3] = '{{8'h53, {14{8'h00}}, 8'hff}, 1'b0, {8'hed, {14{8'h63}}, 8'h16}};
    vecs[4] = '{{16{8'h63}}, 1'b1, 128'h0};
    vecs[5] = '{{8'hed, {14{8'h63}}, 8'h16}, 1'b1, {8'h53, {14{8'h00}}, 8'hff}};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset out_valid", 128'(ov[2]), 128'd0);
    check("reset out_data", od[2], 128'd0);
    check("reset busy", 128'(by[2]), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset in_ready", 128'(ir[2]), 128'd1);

    // Table-driven vectors on LANES=4
    for (int i = 0; i < 6; i++) begin
      run_block(vecs[i].din, vecs[i].inv, res, lat);
      check($sformatf("vec%0d data", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 128'(lat), 128'd4);
    end

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = PT;
    in_inv   = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrun out_valid", 128'(ov[2]), 128'd0);
    check("midrun out_data", od[2], 128'd0);
    check("midrun busy", 128'(by[2]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrun in_ready", 128'(ir[2]), 128'd1);
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ov[2]) pulses++;
    end
    check("midrun no output pulse", 128'(pulses), 128'd0);

    // Back-pressure in DONE, then back-to-back accept on release
    out_ready = 1'b0;
    run_block(PT, 1'b0, held, lat);
    check("bp first data", held, SUB);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = SUB;
    in_inv   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp stall%0d data", k), od[2], SUB);
      check($sformatf("bp stall%0d ready/valid", k), {126'd0, ir[2], ov[2]}, 128'b01);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 128'(ir[2]), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_inv   = 1'b0;
    check("bp b2b valid/busy", {126'd0, ov[2], by[2]}, 128'b01);
    wait_out(res, lat);
    check("bp b2b data", res, PT);
    check("bp b2b latency", 128'(lat), 128'd4);

    // Parameter sweep: all instances take the forward vector on the same edge
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = PT;
    in_inv   = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      slat[i] = -1;
      sres[i] = '0;
    end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
        if (slat[i] < 0 && ov[i]) begin
          slat[i] = k;
          sres[i] = od[i];
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("sweep lanes%0d data", 1 << i), sres[i], SUB);
      check($sformatf("sweep lanes%0d latency", 1 << i), 128'(slat[i]), 128'(16 >> i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
